shared_bus_mem_responder: RTL and testbench

Memory-side responder at the far end of the L2 cache's shared bus. It accepts the bus operations the L2 issues (READ, WRITE, INVALIDATE, RWIM) and runs a snoop window for each one that needs it. It then either services the operation from a small line-granular backing store after a fixed memory latency, or tells the L2 to retry. It stands in for the memory controller so the L2 and snoop logic can be exercised end to end.

---
 rtl/shared_bus_mem_responder_pkg.sv | 24 ++
 rtl/shared_bus_mem_responder_if.sv | 28 ++
 rtl/shared_bus_mem_responder_line_store.sv | 32 +++
 rtl/shared_bus_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_shared_bus_mem_responder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/shared_bus_mem_responder_pkg.sv
// Shared-bus responder types: op/snoop/status codes and FSM state encoding.
// Combinational helpers only; no state lives here.
package shared_bus_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_INVAL = 8'h03;
  localparam logic [7:0] OP_RWIM  = 8'h04;

  localparam logic [1:0] SNP_HIT   = 2'b00;
  localparam logic [1:0] SNP_HITM  = 2'b01;
  localparam logic [1:0] SNP_NOHIT = 2'b10;

  localparam logic [1:0] RESP_OK    = 2'b00;
  localparam logic [1:0] RESP_RETRY = 2'b01;
  localparam logic [1:0] RESP_ERR   = 2'b10;

  typedef enum logic [1:0] {IDLE, SNOOP, ACCESS, RESP} state_t;

  function automatic logic op_legal(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE) || (op == OP_INVAL) || (op == OP_RWIM);
  endfunction

endpackage

// File: rtl/shared_bus_mem_responder_if.sv
// Request / snoop / response signals between the L2 (master) and the memory responder (slave).
// Valid-ready on request and response; snoop result is a one-cycle valid pulse.
interface shared_bus_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512
);
  logic              req_valid;
  logic              req_ready;
  logic [7:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_data;
  logic              snoop_valid;
  logic [1:0]        snoop_result;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_status;
  logic [LINE_W-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_addr, req_data, snoop_valid, snoop_result, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, snoop_valid, snoop_result, resp_ready,
    output req_ready, resp_valid, resp_status, resp_data
  );
endinterface

// File: rtl/shared_bus_mem_responder_line_store.sv
// Line-granular backing store: one-cycle write, combinational read masked by per-line valid bit.
// Valid bits clear asynchronously on reset; line data is never reset.
module shared_bus_line_store #(
  parameter int LINE_W    = 512,
  parameter int MEM_LINES = 64,
  parameter int IW        = $clog2(MEM_LINES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IW-1:0]     wr_idx,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [IW-1:0]     rd_idx,
  output logic [LINE_W-1:0] rd_data
);

  logic [LINE_W-1:0]    mem [MEM_LINES];
  logic [MEM_LINES-1:0] line_valid;

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  line_valid <= '0;
    else if (we) line_valid[wr_idx] <= 1'b1;
  end

  // Never-written lines read as zero rather than exposing stale array contents.
  assign rd_data = line_valid[rd_idx] ? mem[rd_idx] : '0;

endmodule

// File: rtl/shared_bus_mem_responder.sv
// Memory-side shared-bus responder: snoop window, then MEM_LAT-cycle store access or RETRY/ERR.
// One op in flight; req_ready only in IDLE; response held until resp_ready. SHARED_BUS_STATS_EN adds counters.
module shared_bus_mem_responder
  import shared_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 512,
  parameter int MEM_LINES = 64,
  parameter int MEM_LAT   = 4,
  parameter int SNOOP_WIN = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef SHARED_BUS_STATS_EN
  output logic [31:0]                 stat_reads,
  output logic [31:0]                 stat_writes,
  output logic [31:0]                 stat_retries,
  output logic [31:0]                 stat_errors,
`endif
  shared_bus_mem_responder_if.slave   bus
);

  localparam int OFS = $clog2(LINE_W / 8);
  localparam int IW  = $clog2(MEM_LINES);
  localparam int SW  = $clog2(SNOOP_WIN + 1);
  localparam int LW  = $clog2(MEM_LAT + 1);
  localparam logic [SW-1:0] SNOOP_LAST = SW'(SNOOP_WIN - 1);
  localparam logic [LW-1:0] ACC_LAST   = LW'(MEM_LAT - 1);

  state_t            state;
  logic [7:0]        op_q;
  logic [IW-1:0]     idx_q;
  logic [LINE_W-1:0] data_q;
  logic [SW-1:0]     snoop_cnt;
  logic [LW-1:0]     acc_cnt;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [1:0]        resp_status_q;
  logic [LINE_W-1:0] resp_data_q;

  logic              acc_done;
  logic              store_we;
  logic [LINE_W-1:0] store_rd;
  logic              snoop_end;
  logic              snoop_hitm;
  logic              unused_addr;

  assign unused_addr = ^bus.req_addr;

  assign acc_done   = (state == ACCESS) && (acc_cnt == ACC_LAST);
  assign store_we   = acc_done && (op_q == OP_WRITE);
  // A missing snoop result by the last window cycle is taken as NOHIT.
  assign snoop_end  = (state == SNOOP) && (bus.snoop_valid || (snoop_cnt == SNOOP_LAST));
  assign snoop_hitm = bus.snoop_valid && (bus.snoop_result == SNP_HITM);

  shared_bus_line_store #(
    .LINE_W   (LINE_W),
    .MEM_LINES(MEM_LINES),
    .IW       (IW)
  ) u_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (store_we),
    .wr_idx (idx_q),
    .wr_data(data_q),
    .rd_idx (idx_q),
    .rd_data(store_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= '0;
      idx_q         <= '0;
      data_q        <= '0;
      snoop_cnt     <= '0;
      acc_cnt       <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_status_q <= RESP_OK;
      resp_data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            idx_q       <= bus.req_addr[OFS+IW-1:OFS];
            data_q      <= bus.req_data;
            snoop_cnt   <= '0;
            acc_cnt     <= '0;
            req_ready_q <= 1'b0;
            if (!op_legal(bus.req_op)) begin
              state         <= RESP;
              resp_valid_q  <= 1'b1;
              resp_status_q <= RESP_ERR;
              resp_data_q   <= '0;
            end else if (bus.req_op == OP_WRITE) begin
              state <= ACCESS;
            end else begin
              state <= SNOOP;
            end
          end
        end
        SNOOP: begin
          if (snoop_end) begin
            if (snoop_hitm) begin
              state         <= RESP;
              resp_valid_q  <= 1'b1;
              resp_status_q <= RESP_RETRY;
              resp_data_q   <= '0;
            end else if (op_q == OP_INVAL) begin
              state         <= RESP;
              resp_valid_q  <= 1'b1;
              resp_status_q <= RESP_OK;
              resp_data_q   <= '0;
            end else begin
              state <= ACCESS;
            end
          end else begin
            snoop_cnt <= snoop_cnt + 1'b1;
          end
        end
        ACCESS: begin
          if (acc_done) begin
            state         <= RESP;
            resp_valid_q  <= 1'b1;
            resp_status_q <= RESP_OK;
            resp_data_q   <= (op_q == OP_WRITE) ? '0 : store_rd;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state         <= IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_status_q <= RESP_OK;
            resp_data_q   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_status = resp_status_q;
  assign bus.resp_data   = resp_data_q;

`ifdef SHARED_BUS_STATS_EN
  logic resp_fire;
  assign resp_fire = (state == RESP) && bus.resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads   <= '0;
      stat_writes  <= '0;
      stat_retries <= '0;
      stat_errors  <= '0;
    end else if (resp_fire) begin
      if (resp_status_q == RESP_RETRY) stat_retries <= stat_retries + 1'b1;
      if (resp_status_q == RESP_ERR)   stat_errors  <= stat_errors + 1'b1;
      if (resp_status_q == RESP_OK && (op_q == OP_READ || op_q == OP_RWIM))
        stat_reads <= stat_reads + 1'b1;
      if (resp_status_q == RESP_OK && op_q == OP_WRITE)
        stat_writes <= stat_writes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shared_bus_mem_responder.sv
// Directed bench for shared_bus_mem_responder with MEM_LAT=4, SNOOP_WIN=3.
// Cycle 1 is the cycle after the request handshake edge; outputs are sampled on the falling edge.
module tb_shared_bus_mem_responder;

  localparam int LINE_W = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   t0 = 0;

  logic [1:0]        st;
  logic [LINE_W-1:0] dat;
  int                rc;
  logic [LINE_W-1:0] pat_d;
  logic [LINE_W-1:0] pat_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shared_bus_mem_responder_if #(.ADDR_W(32), .LINE_W(LINE_W)) bus ();

`ifdef SHARED_BUS_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_retries, stat_errors;
`endif

  shared_bus_mem_responder #(
    .ADDR_W(32), .LINE_W(LINE_W), .MEM_LINES(64), .MEM_LAT(4), .SNOOP_WIN(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef SHARED_BUS_STATS_EN
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_retries(stat_retries),
    .stat_errors (stat_errors),
`endif
    .bus         (bus)
  );

  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [LINE_W-1:0] d);
    int n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_data  = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    t0 = cyc;
  endtask

  // Returns at the falling edge where resp_valid is first seen; rcyc = -1 if it never rises.
  task automatic wait_resp(input int snp_cyc, input logic [1:0] snp_res,
                           output int rcyc, output logic [1:0] s, output logic [LINE_W-1:0] d);
    rcyc = -1;
    s    = 2'bxx;
    d    = 'x;
    for (int c = 1; c <= 40; c++) begin
      bus.snoop_valid  = (c == snp_cyc);
      bus.snoop_result = (c == snp_cyc) ? snp_res : 2'b00;
      @(negedge clk);
      if (bus.resp_valid) begin
        rcyc = cyc - t0 + 1;
        s    = bus.resp_status;
        d    = bus.resp_data;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.snoop_valid = 1'b0;
  endtask

  task automatic take();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [LINE_W-1:0] d,
                       input int snp_cyc, input logic [1:0] snp_res);
    issue(op, addr, d);
    wait_resp(snp_cyc, snp_res, rc, st, dat);
    if (rc > 0) take();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.resp_status !== 2'b00) begin failures++; $display("FAIL reset_resp_status got=%b exp=00", bus.resp_status); end
    checks++; if (bus.resp_data !== '0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", bus.resp_data); end
  endtask

  task automatic test_read_empty();
    do_op(8'h01, 32'h0000_0040, '0, 1, 2'b10);
    checks++; if (rc != 6) begin failures++; $display("FAIL read_empty_cycle got=%0d exp=6", rc); end
    checks++; if (st !== 2'b00) begin failures++; $display("FAIL read_empty_status got=%b exp=00", st); end
    checks++; if (dat !== '0) begin failures++; $display("FAIL read_empty_data got=%h exp=0", dat); end
  endtask

  task automatic test_write_read();
    // Snoop pulse during a WRITE is outside SNOOP and must be ignored.
    do_op(8'h02, 32'h0000_0080, pat_d, 1, 2'b01);
    checks++; if (rc != 5) begin failures++; $display("FAIL write_cycle got=%0d exp=5", rc); end
    checks++; if (st !== 2'b00) begin failures++; $display("FAIL write_status got=%b exp=00", st); end
    checks++; if (dat !== '0) begin failures++; $display("FAIL write_data got=%h exp=0", dat); end
    do_op(8'h01, 32'h0000_1080, '0, 1, 2'b00);
    checks++; if (rc != 6) begin failures++; $display("FAIL alias_read_cycle got=%0d exp=6", rc); end
    checks++; if (st !== 2'b00) begin failures++; $display("FAIL alias_read_status got=%b exp=00", st); end
    checks++; if (dat !== pat_d) begin failures++; $display("FAIL alias_read_data got=%h exp=%h", dat, pat_d); end
  endtask

  task automatic test_rwim_retry();
    do_op(8'h04, 32'h0000_0080, '0, 2, 2'b01);
    checks++; if (rc != 3) begin failures++; $display("FAIL rwim_retry_cycle got=%0d exp=3", rc); end
    checks++; if (st !== 2'b01) begin failures++; $display("FAIL rwim_retry_status got=%b exp=01", st); end
    checks++; if (dat !== '0) begin failures++; $display("FAIL rwim_retry_data got=%h exp=0", dat); end
    do_op(8'h01, 32'h0000_0080, '0, 2, 2'b11);
    checks++; if (rc != 7) begin failures++; $display("FAIL read_after_retry_cycle got=%0d exp=7", rc); end
    checks++; if (st !== 2'b00) begin failures++; $display("FAIL read_after_retry_status got=%b exp=00", st); end
    checks++; if (dat !== pat_d) begin failures++; $display("FAIL read_after_retry_data got=%h exp=%h", dat, pat_d); end
  endtask

  task automatic test_snoop_timeout();
    do_op(8'h03, 32'h0000_0080, '0, 0, 2'b00);
    checks++; if (rc != 4) begin failures++; $display("FAIL inval_timeout_cycle got=%0d exp=4", rc); end
    checks++; if (st !== 2'b00) begin failures++; $display("FAIL inval_timeout_status got=%b exp=00", st); end
    do_op(8'h01, 32'h0000_0080, '0, 0, 2'b00);
    checks++; if (rc != 8) begin failures++; $display("FAIL read_timeout_cycle got=%0d exp=8", rc); end
    checks++; if (dat !== pat_d) begin failures++; $display("FAIL read_timeout_data got=%h exp=%h", dat, pat_d); end
  endtask

  task automatic test_illegal_op();
    do_op(8'h07, 32'h0000_0080, pat_e, 1, 2'b00);
    checks++; if (rc != 1) begin failures++; $display("FAIL illegal_cycle got=%0d exp=1", rc); end
    checks++; if (st !== 2'b10) begin failures++; $display("FAIL illegal_status got=%b exp=10", st); end
    checks++; if (dat !== '0) begin failures++; $display("FAIL illegal_data got=%h exp=0", dat); end
  endtask

  task automatic test_back_to_back();
    issue(8'h01, 32'h0000_0080, '0);
    wait_resp(1, 2'b10, rc, st, dat);
    checks++; if (rc != 6) begin failures++; $display("FAIL hold_first_cycle got=%0d exp=6", rc); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_status !== 2'b00 || bus.resp_data !== pat_d || bus.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d] got vld=%b st=%b rdy=%b data_ok=%b exp vld=1 st=00 rdy=0 data_ok=1",
                 i, bus.resp_valid, bus.resp_status, bus.req_ready, bus.resp_data === pat_d);
      end
    end
    take();
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL post_take_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL post_take_req_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_reset_mid_write();
    issue(8'h02, 32'h0000_00C0, pat_e);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL midreset_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL midreset_req_ready got=%b exp=1", bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h01, 32'h0000_00C0, '0, 1, 2'b10);
    checks++; if (dat !== '0) begin failures++; $display("FAIL discarded_write_data got=%h exp=0", dat); end
    do_op(8'h01, 32'h0000_0080, '0, 1, 2'b10);
    checks++; if (rc != 6) begin failures++; $display("FAIL cleared_line_cycle got=%0d exp=6", rc); end
    checks++; if (dat !== '0) begin failures++; $display("FAIL cleared_line_data got=%h exp=0", dat); end
  endtask

  initial begin
    pat_d            = {8{64'hDEAD_BEEF_0123_4567}};
    pat_e            = {8{64'h0F1E_2D3C_4B5A_6978}};
    bus.req_valid    = 1'b0;
    bus.req_op       = 8'h00;
    bus.req_addr     = '0;
    bus.req_data     = '0;
    bus.snoop_valid  = 1'b0;
    bus.snoop_result = 2'b00;
    bus.resp_ready   = 1'b0;
    test_reset();
    test_read_empty();
    test_write_read();
    test_rwim_retry();
    test_snoop_timeout();
    test_illegal_op();
    test_back_to_back();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
